// File: rtl/search_frame_loader_pkg.sv
// search_frame_loader_pkg
// Shared definitions for the search frame loader: FSM state encoding, frame
// word-index constants and the default header magic byte.
// Optional feature macro: SEARCH_FRAME_CHECKSUM_EN (adds the w19 checksum word).
package search_frame_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      RESP0,
      RESP1,
      ERR
   } loaderState_t;

   localparam logic [4:0] W_HDR      = 5'd0;
   localparam logic [4:0] W_CNT      = 5'd1;
   localparam logic [4:0] W_INC      = 5'd2;
   localparam logic [4:0] W_MSG0     = 5'd3;
   localparam logic [4:0] W_MSG_LAST = 5'd18;
   localparam logic [4:0] W_CSUM     = 5'd19;

   localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hC5;

   // Index of the word whose acceptance completes a frame.
   function automatic logic [4:0] lastWordIndex();
`ifdef SEARCH_FRAME_CHECKSUM_EN
      return W_CSUM;
`else
      return W_MSG_LAST;
`endif
   endfunction

endpackage

// File: rtl/search_frame_deserializer.sv
// search_frame_deserializer
// Turns accepted host words into frame fields. Owns the word index, the
// target/counter/increment/message registers and, when SEARCH_FRAME_CHECKSUM_EN
// is defined, the running XOR checksum.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   accept            a host word is transferred this cycle
//   inIdle            parent FSM is in IDLE (accepted word is a header candidate)
//   wordData          host word
//   headerAccept      header with matching magic accepted this cycle
//   frameComplete     last word of the frame accepted this cycle
//   frameBad          (checksum build) completing word fails the checksum
//   wordIndex         (checksum build) index of the word being accepted
//   target, counter, increment, message   assembled frame fields
module search_frame_deserializer
   import search_frame_loader_pkg::*;
#(
   parameter logic [7:0]  HDR_MAGIC = HDR_MAGIC_DEFAULT,
   parameter int unsigned MSG_WORDS = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         accept,
   input  logic         inIdle,
   input  logic [31:0]  wordData,
   output logic         headerAccept,
   output logic         frameComplete,
`ifdef SEARCH_FRAME_CHECKSUM_EN
   output logic         frameBad,
   output logic [4:0]   wordIndex,
`endif
   output logic [4:0]   target,
   output logic [31:0]  counter,
   output logic [31:0]  increment,
   output logic [511:0] message
);

   localparam logic [4:0] LAST_IDX = lastWordIndex();

`ifndef SEARCH_FRAME_CHECKSUM_EN
   logic [4:0] wordIndex;
`endif

   logic loadAccept;

   assign headerAccept  = accept && inIdle && (wordData[31:24] == HDR_MAGIC);
   assign loadAccept    = accept && !inIdle;
   assign frameComplete = loadAccept && (wordIndex == LAST_IDX);

`ifdef SEARCH_FRAME_CHECKSUM_EN
   logic [31:0] csum;

   // csum holds XOR of w0..w18 by the time w19 arrives.
   assign frameBad = frameComplete && (wordData != csum);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (headerAccept) begin
         csum <= wordData;
      end else if (loadAccept) begin
         csum <= csum ^ wordData;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wordIndex <= '0;
         target    <= '0;
         counter   <= '0;
         increment <= '0;
         message   <= '0;
      end else if (headerAccept) begin
         target    <= wordData[4:0];
         wordIndex <= W_CNT;
      end else if (loadAccept) begin
         if (wordIndex == W_CNT) counter <= wordData;
         if (wordIndex == W_INC) increment <= wordData;
         // w3 lands in the top 32 bits, w18 in the bottom 32 bits.
         for (int i = 0; i < int'(MSG_WORDS); i++) begin
            if (wordIndex == 5'(int'(W_MSG0) + i)) begin
               message[32*(int'(MSG_WORDS)-1-i) +: 32] <= wordData;
            end
         end
         // Index is left on the last word so an error response can report it.
         if (!frameComplete) wordIndex <= wordIndex + 5'd1;
      end
   end

endmodule

// File: rtl/search_frame_loader.sv
// search_frame_loader
// Upstream feeder for the collision searcher. Assembles a frame from the host
// word stream, pulses srch_start, waits for srch_done and returns the result
// and digest count as a two-word response stream.
// Optional feature macro: SEARCH_FRAME_CHECKSUM_EN -- frame carries a w19 XOR
// checksum; a mismatch produces a single error response word instead of a search.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_data/in_ready  host word stream in
//   out_valid/out_data/out_last/out_error/out_ready   response stream out
//   busy                       high outside IDLE and LOAD
//   srch_start, srch_target, srch_message, srch_counter, srch_increment  to searcher
//   srch_digests, srch_done, srch_result                                 from searcher
module search_frame_loader
   import search_frame_loader_pkg::*;
#(
   parameter logic [7:0]  HDR_MAGIC = HDR_MAGIC_DEFAULT,
   parameter int unsigned MSG_WORDS = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [31:0]  in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [31:0]  out_data,
   output logic         out_last,
   output logic         out_error,
   input  logic         out_ready,
   output logic         busy,
   output logic         srch_start,
   output logic [4:0]   srch_target,
   output logic [511:0] srch_message,
   output logic [31:0]  srch_counter,
   output logic [31:0]  srch_increment,
   input  logic [31:0]  srch_digests,
   input  logic         srch_done,
   input  logic [31:0]  srch_result
);

   if (MSG_WORDS != 16) begin : gMsgWordsCheck
      $error("search_frame_loader: MSG_WORDS must be 16 (512-bit message)");
   end

   loaderState_t state;
   logic         headerAccept;
   logic         frameComplete;
   logic [31:0]  countQ;

`ifdef SEARCH_FRAME_CHECKSUM_EN
   logic         frameBad;
   logic [4:0]   wordIndex;
   logic         outErrorQ;
   assign out_error = outErrorQ;
`else
   assign out_error = 1'b0;
`endif

   search_frame_deserializer #(
      .HDR_MAGIC (HDR_MAGIC),
      .MSG_WORDS (MSG_WORDS)
   ) uDeser (
      .clk           (clk),
      .reset         (reset),
      .accept        (in_valid && in_ready),
      .inIdle        (state == IDLE),
      .wordData      (in_data),
      .headerAccept  (headerAccept),
      .frameComplete (frameComplete),
`ifdef SEARCH_FRAME_CHECKSUM_EN
      .frameBad      (frameBad),
      .wordIndex     (wordIndex),
`endif
      .target        (srch_target),
      .counter       (srch_counter),
      .increment     (srch_increment),
      .message       (srch_message)
   );

   // Outputs are registered and updated alongside the state they belong to.
   // The result is loaded straight into out_data; only the count needs holding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         srch_start <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         countQ     <= '0;
`ifdef SEARCH_FRAME_CHECKSUM_EN
         outErrorQ  <= 1'b0;
`endif
      end else begin
         srch_start <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (headerAccept) state <= LOAD;
            end
            LOAD: begin
               if (frameComplete) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
`ifdef SEARCH_FRAME_CHECKSUM_EN
                  if (frameBad) begin
                     state     <= ERR;
                     out_valid <= 1'b1;
                     outErrorQ <= 1'b1;
                     out_last  <= 1'b1;
                     out_data  <= {27'b0, wordIndex};
                  end else begin
`else
                  begin
`endif
                     state      <= START;
                     srch_start <= 1'b1;
                  end
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (srch_done) begin
                  state     <= RESP0;
                  out_valid <= 1'b1;
                  out_data  <= srch_result;
                  out_last  <= 1'b0;
                  countQ    <= srch_digests;
               end
            end
            RESP0: begin
               if (out_ready) begin
                  state    <= RESP1;
                  out_data <= countQ;
                  out_last <= 1'b1;
               end
            end
            RESP1: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
`ifdef SEARCH_FRAME_CHECKSUM_EN
            ERR: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  outErrorQ <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_search_frame_loader.sv
module tb_search_frame_loader;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic         out_last;
   logic         out_error;
   logic         out_ready;
   logic         busy;
   logic         srch_start;
   logic [4:0]   srch_target;
   logic [511:0] srch_message;
   logic [31:0]  srch_counter;
   logic [31:0]  srch_increment;
   logic [31:0]  srch_digests;
   logic         srch_done;
   logic [31:0]  srch_result;

   search_frame_loader dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_last       (out_last),
      .out_error      (out_error),
      .out_ready      (out_ready),
      .busy           (busy),
      .srch_start     (srch_start),
      .srch_target    (srch_target),
      .srch_message   (srch_message),
      .srch_counter   (srch_counter),
      .srch_increment (srch_increment),
      .srch_digests   (srch_digests),
      .srch_done      (srch_done),
      .srch_result    (srch_result)
   );

   typedef struct packed {
      logic        err;
      logic        last;
      logic [31:0] data;
   } resp_t;

   resp_t expQ[$];
   int checks = 0;
   int errors = 0;
   int startCount = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response scoreboard: compare each transferred word against the queue head.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            check("unexpected_resp", out_valid, 1'b0);
         end else begin
            resp_t e;
            e = expQ.pop_front();
            check("resp_data", out_data, e.data);
            check("resp_last", out_last, e.last);
            check("resp_error", out_error, e.err);
         end
      end
   end

   always @(negedge clk) if (reset && srch_start) startCount++;

   task automatic sendWord(input logic [31:0] w);
      bit got;
      bit acc;
      got = 0;
      in_valid = 1'b1;
      in_data  = w;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            got = 1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!got) check("word_accept_timeout", in_ready, 1'b1);
   endtask

   task automatic sendFrame(input logic [31:0] hdr, input logic [31:0] cnt,
                            input logic [31:0] inc, input logic [31:0] base,
                            input bit gap, input bit corrupt,
                            output logic [511:0] msgExp);
      logic [31:0] csum;
      logic [31:0] w;
      csum = hdr ^ cnt ^ inc;
      msgExp = '0;
      sendWord(hdr);
      if (gap) begin @(posedge clk); #1; end
      sendWord(cnt);
      if (gap) begin @(posedge clk); #1; end
      sendWord(inc);
      for (int i = 0; i < 16; i++) begin
         if (gap) begin @(posedge clk); #1; end
         w = base + 32'(i);
         csum = csum ^ w;
         msgExp[32*(15-i) +: 32] = w;
         sendWord(w);
      end
`ifdef SEARCH_FRAME_CHECKSUM_EN
      if (gap) begin @(posedge clk); #1; end
      sendWord(corrupt ? (csum ^ 32'h0000_0100) : csum);
`else
      if (corrupt) csum = '0;
`endif
   endtask

   // Returns the number of falling edges until srch_start is seen (0 = never).
   task automatic waitStart(output int lat);
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (srch_start) begin
            lat = n;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doneAfter(input int delay, input logic [31:0] res, input logic [31:0] dig);
      expQ.push_back('{err: 1'b0, last: 1'b0, data: res});
      expQ.push_back('{err: 1'b0, last: 1'b1, data: dig});
      repeat (delay) begin @(posedge clk); #1; end
      srch_done    = 1'b1;
      srch_result  = res;
      srch_digests = dig;
      @(posedge clk);
      #1;
      srch_done    = 1'b0;
      srch_result  = 32'hDEAD_BEEF;
      srch_digests = 32'hBAD0_BAD0;
   endtask

   task automatic waitDrain(input string tag);
      for (int n = 0; n < 200; n++) begin
         if (expQ.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check(tag, expQ.size(), 0);
      @(posedge clk);
      #1;
   endtask

   logic [511:0] msgExp;
   int lat;
   int startsBefore;

   initial begin
      reset        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b1;
      srch_done    = 1'b0;
      srch_result  = '0;
      srch_digests = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_srch_start", srch_start, 1'b0);
      check("rst_srch_message", srch_message[63:0], 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("idle_in_ready", in_ready, 1'b1);

      // Good frame
      startsBefore = startCount;
      sendFrame(32'hC500_0008, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0, msgExp);
      waitStart(lat);
      check("start_latency", lat, 1);
      check("target", srch_target, 5'd8);
      check("counter", srch_counter, 32'd0);
      check("increment", srch_increment, 32'd1);
      check("msg_top", srch_message[511:480], 32'd1);
      check("msg_all_hi", srch_message[511:256], msgExp[511:256]);
      check("msg_all_lo", srch_message[255:0], msgExp[255:0]);
      check("busy_wait", busy, 1'b1);
      check("in_ready_wait", in_ready, 1'b0);
      doneAfter(40, 32'h0000_1234, 32'h0000_1235);
      @(negedge clk);
      check("done_to_valid", out_valid, 1'b1);
      waitDrain("good_drain");
      check("good_one_start", startCount - startsBefore, 1);
      check("good_idle_busy", busy, 1'b0);

      // Bad magic, then a valid frame with different fields
      sendWord(32'hAA00_0008);
      @(negedge clk);
      check("badmagic_in_ready", in_ready, 1'b1);
      check("badmagic_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      sendFrame(32'hC5FF_FF13, 32'h1111_0000, 32'h0000_0007, 32'h5000_0000, 1'b0, 1'b0,
                msgExp);
      waitStart(lat);
      check("bm_start_latency", lat, 1);
      check("bm_target", srch_target, 5'h13);
      check("bm_counter", srch_counter, 32'h1111_0000);
      check("bm_increment", srch_increment, 32'd7);
      check("bm_msg_hi", srch_message[511:256], msgExp[511:256]);
      check("bm_msg_lo", srch_message[255:0], msgExp[255:0]);
      doneAfter(3, 32'hCAFE_0001, 32'h0000_0042);
      waitDrain("bm_drain");

      // Backpressure: gapped input, response held for 10 cycles
      startsBefore = startCount;
      sendFrame(32'hC500_001F, 32'hFFFF_FFF0, 32'h8000_0001, 32'hA5A5_0000, 1'b1, 1'b0,
                msgExp);
      waitStart(lat);
      check("bp_msg_hi", srch_message[511:256], msgExp[511:256]);
      check("bp_msg_lo", srch_message[255:0], msgExp[255:0]);
      check("bp_target", srch_target, 5'h1F);
      out_ready = 1'b0;
      doneAfter(5, 32'h0BAD_F00D, 32'h7777_0000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0 || i == 5 || i == 9) begin
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data", out_data, 32'h0BAD_F00D);
            check("bp_hold_last", out_last, 1'b0);
         end
      end
      @(posedge clk);
      #1;
      check("bp_stable_msg", srch_message[255:0], msgExp[255:0]);
      out_ready = 1'b1;
      waitDrain("bp_drain");
      check("bp_one_start", startCount - startsBefore, 1);

      // Spurious done in IDLE
      srch_done   = 1'b1;
      srch_result = 32'h1357_9BDF;
      @(posedge clk);
      #1;
      srch_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("spurious_out_valid", out_valid, 1'b0);
      check("spurious_busy", busy, 1'b0);
      @(posedge clk);
      #1;

      // Reset during WAIT
      sendFrame(32'hC500_0004, 32'd10, 32'd2, 32'd100, 1'b0, 1'b0, msgExp);
      waitStart(lat);
      repeat (3) begin @(posedge clk); #1; end
      check("prereset_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("rstwait_busy", busy, 1'b0);
      check("rstwait_start", srch_start, 1'b0);
      check("rstwait_out_valid", out_valid, 1'b0);
      check("rstwait_in_ready", in_ready, 1'b0);
      check("rstwait_target", srch_target, 5'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      sendFrame(32'hC500_0009, 32'd3, 32'd4, 32'd200, 1'b0, 1'b0, msgExp);
      waitStart(lat);
      check("post_rst_latency", lat, 1);
      check("post_rst_msg_lo", srch_message[255:0], msgExp[255:0]);
      doneAfter(2, 32'h0000_00AB, 32'h0000_00CD);
      waitDrain("post_rst_drain");

`ifdef SEARCH_FRAME_CHECKSUM_EN
      // Corrupt checksum
      startsBefore = startCount;
      expQ.push_back('{err: 1'b1, last: 1'b1, data: 32'd19});
      sendFrame(32'hC500_0008, 32'd0, 32'd1, 32'd1, 1'b0, 1'b1, msgExp);
      waitDrain("csum_drain");
      check("csum_no_start", startCount - startsBefore, 0);
      check("csum_idle_busy", busy, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
